// File: rtl/serial_subtract_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor sequencer.
//   state_e          : FSM state encoding (IDLE, SHIFT, DONE; binary)
//   WIDTH_MIN/MAX    : legal operand width range, checked at elaboration
//   width_is_legal() : helper used by the elaboration check
package serial_subtract_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_is_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_subtract_ctrl_if.sv
// Handshake/operand bundle between the arithmetic datapath and the
// bit-serial subtractor sequencer.
//   start      : request, honoured only when the sequencer is idle or done
//   a, b, bin  : minuend, subtrahend, initial borrow (captured with start)
//   busy       : high while bits are being shifted through the cell
//   done       : one-cycle pulse, diff/borrow_out valid
//   diff       : a - b - bin modulo 2^WIDTH
//   borrow_out : final borrow (a < b + bin, unsigned)
// master = requester side, slave = the sequencer.
interface serial_subtract_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/serial_subtract_ctrl_full_subtractor.sv
// One-bit full subtractor cell: computes a - b - bin.
//   a, b, bin : operand bits and incoming borrow
//   diff      : difference bit
//   borrow    : outgoing borrow
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrow
);

  // Borrow when b exceeds a, or when they are equal and a borrow comes in.
  assign diff   = a ^ b ^ bin;
  assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Sequencer for a WIDTH-bit bit-serial subtractor (a - b - bin, LSB first).
// One full_subtractor cell is reused every cycle; the borrow between bits is
// registered. Result latency is WIDTH+1 cycles from the start cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : slave side of serial_subtract_ctrl_if (start/a/b/bin in,
//           busy/done/diff/borrow_out out)
module serial_subtract_ctrl
  import serial_subtract_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_subtract_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  generate
    if (!width_is_legal(WIDTH)) begin : g_bad_width
      $error("serial_subtract_ctrl: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               brw_q, brw_d;
  logic               borrow_out_q, borrow_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cell_diff;
  logic               cell_borrow;
  logic               last_bit;

  full_subtractor u_fs (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .bin    (brw_q),
    .diff   (cell_diff),
    .borrow (cell_borrow)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state logic. IDLE and DONE share the operand load so a start held
  // in DONE launches the next op without passing through IDLE. The result
  // register fills from the MSB end, so after WIDTH shifts bit 0 of the
  // operands lands at bit 0 of res. diff/borrow_out only change on DONE entry.
  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    brw_d        = brw_q;
    borrow_out_d = borrow_out_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = (res_q >> 1) | {cell_diff, {(WIDTH-1){1'b0}}};
        brw_d  = cell_borrow;
        if (last_bit) begin
          diff_d       = res_d;
          borrow_out_d = cell_borrow;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      brw_q        <= 1'b0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      brw_q        <= brw_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Self-checking bench for serial_subtract_ctrl (WIDTH=8): directed vector
// table, reset mid-operation, start during SHIFT, back-to-back start, and a
// random sweep against an arithmetic reference model.
module tb_serial_subtract_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_subtract_ctrl_if #(.WIDTH(W)) bus ();

  serial_subtract_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {borrow, diff} is the 9-bit two's-complement result of a-b-bin.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bin);
    return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic bin);
    bus.start = st;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
  endtask

  // Called at a negedge. Launches one op, scrambles operands after the
  // accept edge, and waits (bounded) for done.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bo, output int lat, output int nbusy);
    applyStimulus(1'b1, a, b, bin);
    @(posedge clk);
    lat   = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      if (lat == 0) applyStimulus(1'b0, W'($urandom), W'($urandom), 1'($urandom));
      lat++;
      if (bus.busy === 1'b1) nbusy++;
    end while (bus.done !== 1'b1 && lat < 40);
    if (bus.done !== 1'b1) checkOutput("done_timeout", 32'(bus.done), 32'd1);
    d  = bus.diff;
    bo = bus.borrow_out;
    @(negedge clk);
    checkOutput("done_width", 32'(bus.done), 32'd0);
  endtask

  initial begin
    vec_t         vecs[7];
    logic [W-1:0] d;
    logic         bo;
    int           lat;
    int           nbusy;
    logic [W:0]   m;
    logic [W-1:0] ra, rb;
    logic         rbin;

    checks = 0;
    errors = 0;
    applyStimulus(1'b0, '0, '0, 1'b0);

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};

    // Reset state
    rst_n = 1'b0;
    #12;
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_diff", 32'(bus.diff), 32'd0);
    checkOutput("rst_borrow", 32'(bus.borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      runOp(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, lat, nbusy);
      checkOutput($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].exp_diff));
      checkOutput($sformatf("vec%0d_borrow", i), 32'(bo), 32'(vecs[i].exp_borrow));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 1));
      checkOutput($sformatf("vec%0d_busy_cycles", i), 32'(nbusy), 32'(W));
    end

    // Held outputs persist after done and are nonzero before the reset test
    checkOutput("hold_diff", 32'(bus.diff), 32'h0FF);

    // Reset mid-SHIFT: outputs clear immediately, not at the next edge
    applyStimulus(1'b1, 8'hC3, 8'h12, 1'b0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_done", 32'(bus.done), 32'd0);
    checkOutput("midrst_diff", 32'(bus.diff), 32'd0);
    checkOutput("midrst_borrow", 32'(bus.borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runOp(8'hC3, 8'h12, 1'b1, d, bo, lat, nbusy);
    checkOutput("post_rst_diff", 32'(d), 32'h0B0);
    checkOutput("post_rst_borrow", 32'(bo), 32'd0);
    checkOutput("post_rst_latency", 32'(lat), 32'(W + 1));

    // start during SHIFT is ignored
    applyStimulus(1'b1, 8'h40, 8'h11, 1'b0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'h01, 8'h99, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    lat = 3;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("ignore_latency", 32'(lat), 32'(W + 1));
    checkOutput("ignore_diff", 32'(bus.diff), 32'h02F);
    checkOutput("ignore_borrow", 32'(bus.borrow_out), 32'd0);
    @(negedge clk);
    checkOutput("ignore_no_second_op", 32'(bus.busy), 32'd0);

    // start held in DONE: back-to-back with no IDLE gap
    applyStimulus(1'b1, 8'h10, 8'h20, 1'b0);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.done !== 1'b1 && lat < 40);
    checkOutput("b2b_first_latency", 32'(lat), 32'(W + 1));
    checkOutput("b2b_first_diff", 32'(bus.diff), 32'h0F0);
    checkOutput("b2b_first_borrow", 32'(bus.borrow_out), 32'd1);
    applyStimulus(1'b1, 8'h33, 8'h22, 1'b1);
    @(negedge clk);
    checkOutput("b2b_no_idle", 32'(bus.busy), 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b_interval", 32'(lat), 32'(W + 1));
    checkOutput("b2b_second_diff", 32'(bus.diff), 32'h010);
    checkOutput("b2b_second_borrow", 32'(bus.borrow_out), 32'd0);
    @(negedge clk);

    // Random sweep against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      m    = model(ra, rb, rbin);
      runOp(ra, rb, rbin, d, bo, lat, nbusy);
      checkOutput($sformatf("rand%0d_diff", i), 32'(d), 32'(m[W-1:0]));
      checkOutput($sformatf("rand%0d_borrow", i), 32'(bo), 32'(m[W]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
